// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and counter sizing helper,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // Width of a counter that must be able to reach the given threshold.
  function automatic int unsigned cnt_width(input int unsigned threshold);
    return $clog2(threshold) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial line synchroniser plus optional 3-tap majority voter
// (UART_RX_MAJORITY_EN).
module uart_rx_sampler #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic i_divided_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_rx,
  output logic o_rxs,
  output logic o_sample
);

  logic sync_q;

  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= IDLE_LEVEL;
      o_rxs  <= IDLE_LEVEL;
    end else begin
      sync_q <= i_rx;
      o_rxs  <= sync_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History advances on enabled ticks only, so the taps are one tick apart
  // in the receiver's time base even when i_en is throttled.
  logic hist1_q, hist2_q;

  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      hist1_q <= IDLE_LEVEL;
      hist2_q <= IDLE_LEVEL;
    end else if (i_en) begin
      hist1_q <= o_rxs;
      hist2_q <= hist1_q;
    end
  end

  assign o_sample = (o_rxs & hist1_q) | (o_rxs & hist2_q) | (hist1_q & hist2_q);
`else
  logic unused_en;
  assign unused_en = i_en;
  assign o_sample  = o_rxs;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with valid/ready output. Optional majority
// sampling is selected by UART_RX_MAJORITY_EN.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA       = 8,
  parameter int unsigned STOP       = 1,
  parameter int unsigned OSR        = 16,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic            i_divided_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_rx,
  input  logic            i_ready,
  output logic [DATA-1:0] o_data,
  output logic            o_valid,
  output logic            o_frame_err,
  output logic            o_overrun,
  output logic [1:0]      d_state
);

  localparam int unsigned HALF    = OSR / 2;
  localparam int unsigned BIT_MAX = (DATA > STOP) ? DATA : STOP;
  localparam int unsigned TW      = cnt_width(OSR);
  localparam int unsigned BW      = cnt_width(BIT_MAX);

`ifdef UART_RX_MAJORITY_EN
  // Voting needs the tick after the nominal point; delaying only the start
  // decision shifts every later sample by the same one tick.
  localparam logic [TW-1:0] START_PT = TW'(HALF);
`else
  localparam logic [TW-1:0] START_PT = TW'(HALF - 1);
`endif
  localparam logic [TW-1:0] BIT_PT    = TW'(OSR - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP - 1);

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DATA-1:0] shreg_q, shreg_d;
  logic            err_q, err_d;
  logic            done, done_err;
  logic            rxs, sample;

  uart_rx_sampler #(.IDLE_LEVEL(IDLE_LEVEL)) u_sampler (
    .i_divided_clk (i_divided_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_rx          (i_rx),
    .o_rxs         (rxs),
    .o_sample      (sample)
  );

  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    err_d    = err_q;
    done     = 1'b0;
    done_err = 1'b0;
    if (i_en) begin
      case (state_q)
        S_IDLE: begin
          if (rxs == ~IDLE_LEVEL) begin
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
            err_d   = 1'b0;
          end
        end
        S_START: begin
          if (tick_q == START_PT) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = (sample == ~IDLE_LEVEL) ? S_DATA : S_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == BIT_PT) begin
            tick_d  = '0;
            shreg_d = {sample, shreg_q[DATA-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == BIT_PT) begin
            tick_d = '0;
            if (sample != IDLE_LEVEL) err_d = 1'b1;
            if (bit_q == STOP_LAST) begin
              done     = 1'b1;
              done_err = err_q | (sample != IDLE_LEVEL);
              bit_d    = '0;
              err_d    = 1'b0;
              state_d  = S_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  // Handshake clear runs every cycle; a completing frame overrides it.
  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (done) begin
        if (done_err) begin
          o_frame_err <= 1'b1;
        end else if (!o_valid || i_ready) begin
          o_data  <= shreg_q;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

  assign d_state = state_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Oversampling UART receiver and the counterpart of the team's UART transmitter. It runs on the same divided, oversampled clock domain (i_divided_clk = OSR × baud). It synchronises the serial line, detects and validates the start bit, samples each data bit at mid-bit, checks the stop bits, and presents the received word on a valid/ready handshake. OSR is supported at any value ≥4, not only powers of two: bit timing uses counters compared against thresholds, not shifts.

Parameters:
DATA, 8, data bits per frame, LSB first.
STOP, 1, stop bits checked per frame (1 or 2).
OSR, 16, i_divided_clk ticks per bit; any integer ≥4.
IDLE_LEVEL, 1, line level when idle and during stop bits; start bit is ~IDLE_LEVEL.

Ports:
i_divided_clk  in   1     oversampled clock.
i_rst          in   1     asynchronous, active-high reset.
i_en           in   1     tick enable; when low, all state is frozen except the synchroniser.
i_rx           in   1     asynchronous serial line.
i_ready        in   1     consumer accepts o_data this cycle.
o_data         out  DATA  received word.
o_valid        out  1     o_data holds an unconsumed word.
o_frame_err    out  1     one-cycle pulse: a stop bit was sampled at the wrong level.
o_overrun      out  1     one-cycle pulse: a completed word was dropped because o_valid was still high.
d_state        out  2     debug: current state encoding.

Behaviour:
- Reset: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, state=IDLE, all counters 0, synchroniser flops=IDLE_LEVEL.
- Synchroniser: 2-flop chain on i_rx, always clocked regardless of i_en. Call its output rxs. Adds 2 ticks of latency.
- Constants: HALF = OSR/2 (floor). Tick counter width = $clog2(OSR)+1. Bit counter width = $clog2(max(DATA,STOP))+1.
- All FSM, counter, and shift-register updates happen only when i_en=1.
- State machine:
  - IDLE: when rxs == ~IDLE_LEVEL, go to START with tick=0.
  - START: increment tick each enabled cycle. When tick == HALF-1, sample rxs:
    - still ~IDLE_LEVEL: go to DATA with tick=0, bit=0.
    - otherwise: false start; return to IDLE with no output.
  - DATA: increment tick. When tick == OSR-1, sample rxs into shreg[bit] (LSB first), set tick=0, bit++. After bit DATA-1 is sampled, go to STOP with bit=0.
  - STOP: same OSR-1 cadence. A sample != IDLE_LEVEL sets an internal error flag. After stop bit STOP-1 is sampled, return to IDLE immediately at mid-bit, so a back-to-back start bit is never missed.
- Completion happens on the tick that samples the final stop bit; outputs update on the next edge:
  - Error flag set: o_frame_err=1 for one cycle; word discarded; o_valid and o_data unchanged.
  - Else if o_valid=0, or o_valid & i_ready in the same cycle: o_data ← shreg, o_valid=1.
  - Else: o_overrun=1 for one cycle; the old o_data is kept.
- Handshake: o_valid & i_ready clears o_valid on the next edge unless a new word loads in the same cycle, in which case o_valid stays 1. i_ready is honoured even when i_en=0.
- Reset asserted mid-frame: immediate return to IDLE; the partial word is lost and no error pulse is produced.
- Illegal state encoding: return to IDLE and clear counters.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each start, data, and stop sample is the 2-of-3 majority of rxs taken at the tick before the nominal sample point, at it, and after it. The decision is made one tick after the nominal point, and the state transition shifts by that one tick. Requires OSR≥4.
- Undefined: single sample at the nominal point as described above.

Decomposition:
- Shared package uart_pkg: state encodings (IDLE=0, START=1, DATA=2, STOP=3) and a function for counter width from a threshold. The transmitter also uses these.
- One sub-module, uart_rx_sampler: the 2-flop synchroniser plus the optional 3-tap majority voter. Outputs rxs and a voted sample.

Test Plan:
- OSR=16, DATA=8, STOP=1; send 0xA5, i_ready=1 → o_data=0xA5 and o_valid high for one cycle, ~(10×16−8+3) ticks after the start edge; no error pulses.
- Start pulse held low for only 4 ticks, then idle → no o_valid, state back to IDLE, next frame 0x3C received correctly.
- Frame with stop bit driven 0 → o_frame_err pulses once, o_valid stays 0; following frame 0x81 received normally.
- i_ready=0, send 0x11 then 0x22 → o_data=0x11 with o_valid held; o_overrun pulses at the end of frame 2. Then raise i_ready → o_valid clears.
- OSR=10, STOP=2, i_en toggling 50%; send 0xF0 → 0xF0 received with timing scaled by enable. Assert i_rst mid-data in the next frame → all outputs at reset values, and the subsequent frame decodes.
- UART_RX_MAJORITY_EN defined, one-tick inverted glitch at the mid-bit of data bit 3 of 0x00 → o_data=0x00. Same stimulus with the macro undefined → o_data=0x08.
